// File: rtl/gray2bin_pipe.sv
// gray2bin_pipe: elastic, pipelined Gray-to-binary decoder with a valid/ready
// handshake on both sides. Each accepted code is also compared against the
// previously accepted code; a Hamming distance above one raises StepError,
// which travels down the pipe alongside that code's decoded value.
module gray2bin_pipe #(
  parameter int N      = 16,
  parameter int STAGES = 2
) (
  input  logic         Clk,
  input  logic         nReset,
  input  logic         InValid,
  output logic         InReady,
  input  logic [N-1:0] GraySignal,
  output logic         OutValid,
  input  logic         OutReady,
  output logic [N-1:0] BinSignal,
  output logic         StepError
);

  // Bits resolved per stage; trailing stages may end up with none.
  localparam int C = (N + STAGES - 1) / STAGES;

  logic [N-1:0]      r_gray [STAGES];
  logic [N-1:0]      r_bin  [STAGES];
  logic [STAGES-1:0] r_vld;
  logic [STAGES-1:0] r_err;
  logic [N-1:0]      r_last_gray;
  logic              r_has_last;

  logic [N-1:0]      w_gray_in  [STAGES];
  logic [N-1:0]      w_bin_in   [STAGES];
  logic [N-1:0]      w_bin_res  [STAGES];
  logic [STAGES-1:0] w_vld_in;
  logic [STAGES-1:0] w_err_in;
  logic [STAGES-1:0] w_load;
  logic              w_accept;
  logic              w_step_err;

  // Resolve the binary bits owned by stage s. Bits above the slice were
  // resolved upstream and arrive in b_in; bits below stay untouched.
  function automatic logic [N-1:0] f_resolve(input logic [N-1:0] g,
                                             input logic [N-1:0] b_in,
                                             input int           s);
    logic [N-1:0] b;
    int           hi;
    int           lo;
    b  = b_in;
    hi = N - 1 - s * C;
    lo = N - (s + 1) * C;
    if (lo < 0) lo = 0;
    if (hi == N - 1) b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      if (i <= hi && i >= lo) b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // A stage can load when it or any stage after it is empty, or when the
  // output is being consumed; this is the unrolled form of the ready chain.
  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_first
      assign w_gray_in[s] = GraySignal;
      assign w_bin_in[s]  = '0;
      assign w_vld_in[s]  = InValid;
      assign w_err_in[s]  = w_step_err;
    end else begin : g_next
      assign w_gray_in[s] = r_gray[s-1];
      assign w_bin_in[s]  = r_bin[s-1];
      assign w_vld_in[s]  = r_vld[s-1];
      assign w_err_in[s]  = r_err[s-1];
    end
    assign w_load[s]    = OutReady || !(&r_vld[STAGES-1:s]);
    assign w_bin_res[s] = f_resolve(w_gray_in[s], w_bin_in[s], s);
  end

  assign InReady    = w_load[0];
  assign w_accept   = InValid && InReady;
  assign w_step_err = r_has_last && ($countones(GraySignal ^ r_last_gray) > 1);

  // Stage registers: advance on load, capture data only for valid entries.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_vld <= '0;
      r_err <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_gray[s] <= '0;
        r_bin[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (w_load[s]) begin
          r_vld[s] <= w_vld_in[s];
          if (w_vld_in[s]) begin
            r_gray[s] <= w_gray_in[s];
            r_bin[s]  <= w_bin_res[s];
            r_err[s]  <= w_err_in[s];
          end
        end
      end
    end
  end

  // Step-check history: only accepted codes update the reference.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_last_gray <= '0;
      r_has_last  <= 1'b0;
    end else if (w_accept) begin
      r_last_gray <= GraySignal;
      r_has_last  <= 1'b1;
    end
  end

  assign OutValid  = r_vld[STAGES-1];
  assign BinSignal = r_bin[STAGES-1];
  assign StepError = r_err[STAGES-1];

endmodule

// File: tb/tb_gray2bin_pipe.sv
// Testbench for gray2bin_pipe: a 4-bit/2-stage instance for table-driven and
// hand-written corner cases, and an 8-bit/3-stage instance for a full-range
// sweep and a randomized handshake run against a reference model.
module tb_gray2bin_pipe;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic nReset;

  logic       iv4, ir4, ov4, or4, se4;
  logic [3:0] g4, b4;
  logic       iv8, ir8, ov8, or8, se8;
  logic [7:0] g8, b8;

  gray2bin_pipe #(.N(4), .STAGES(2)) u_d4 (
    .Clk(Clk), .nReset(nReset), .InValid(iv4), .InReady(ir4), .GraySignal(g4),
    .OutValid(ov4), .OutReady(or4), .BinSignal(b4), .StepError(se4)
  );

  gray2bin_pipe #(.N(8), .STAGES(3)) u_d8 (
    .Clk(Clk), .nReset(nReset), .InValid(iv8), .InReady(ir8), .GraySignal(g8),
    .OutValid(ov8), .OutReady(or8), .BinSignal(b8), .StepError(se8)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: binary bit i is the parity of all Gray bits at or above i.
  function automatic logic [31:0] ref_bin(input logic [31:0] g);
    logic [31:0] b;
    b = '0;
    for (int k = 0; k < 32; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic int hamming(input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    for (int k = 0; k < 32; k++) if (a[k] != b[k]) n++;
    return n;
  endfunction

  function automatic logic [7:0] gray8(input logic [7:0] v);
    return v ^ (v >> 1);
  endfunction

  typedef struct {
    logic [3:0] gray;
    logic [3:0] bin;
    logic       err;
  } vec_t;
  vec_t tv [9];

  typedef struct {
    logic [7:0] bin;
    logic       err;
  } exp_t;
  exp_t exp_q [$];

  task automatic do_reset();
    @(negedge Clk);
    nReset = 1'b0;
    iv4 = 1'b0;
    iv8 = 1'b0;
    repeat (2) @(negedge Clk);
    nReset = 1'b1;
  endtask

  // Stream table entries back-to-back into the 4-bit instance with OutReady=1.
  task automatic run4(input int first, input int n, input string tag);
    int k;
    or4 = 1'b1;
    for (int c = 0; c < n + 1; c++) begin
      if (c < n) begin
        iv4 = 1'b1;
        g4  = tv[first+c].gray;
      end else begin
        iv4 = 1'b0;
      end
      #1;
      if (c < n) check({tag, "_in_ready"}, 32'(ir4), 32'd1);
      @(negedge Clk);
      k = c - 1;
      if (k < 0) begin
        check({tag, "_early_valid"}, 32'(ov4), 32'd0);
      end else begin
        check({tag, "_valid"}, 32'(ov4), 32'd1);
        check({tag, "_bin"}, 32'(b4), 32'(tv[first+k].bin));
        check({tag, "_err"}, 32'(se4), 32'(tv[first+k].err));
      end
    end
    iv4 = 1'b0;
  endtask

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1);
  end

  initial begin
    logic [3:0] bp_code [4];
    logic [3:0] bp_bin  [4];
    logic [3:0] got_b   [8];
    logic       got_e   [8];
    int         got, nxt_i, k;
    logic [7:0] m_last;
    logic       m_has, m_err, acc, con, prev_stall, prev_e;
    logic [7:0] prev_b;
    int         occ, r;
    exp_t       e;

    tv[0] = '{4'b0110, 4'b0100, 1'b0};
    tv[1] = '{4'b1000, 4'b1111, 1'b1};
    tv[2] = '{4'b1111, 4'b1010, 1'b1};
    tv[3] = '{4'b0000, 4'b0000, 1'b0};
    tv[4] = '{4'b0001, 4'b0001, 1'b0};
    tv[5] = '{4'b0011, 4'b0010, 1'b0};
    tv[6] = '{4'b0011, 4'b0010, 1'b0};
    tv[7] = '{4'b0010, 4'b0011, 1'b0};
    tv[8] = '{4'b0111, 4'b0101, 1'b1};
    bp_code = '{4'b0001, 4'b0011, 4'b0010, 4'b0110};
    bp_bin  = '{4'b0001, 4'b0010, 4'b0011, 4'b0100};

    nReset = 1'b1;
    iv4 = 1'b0; g4 = '0; or4 = 1'b1;
    iv8 = 1'b0; g8 = '0; or8 = 1'b1;
    #2 nReset = 1'b0;
    #1;
    check("rst_ov4", 32'(ov4), 32'd0);
    check("rst_b4",  32'(b4),  32'd0);
    check("rst_se4", 32'(se4), 32'd0);
    check("rst_ov8", 32'(ov8), 32'd0);
    check("rst_b8",  32'(b8),  32'd0);
    check("rst_se8", 32'(se8), 32'd0);
    repeat (2) @(negedge Clk);
    nReset = 1'b1;
    #1;
    check("rst_ir4", 32'(ir4), 32'd1);
    check("rst_ir8", 32'(ir8), 32'd1);

    run4(0, 3, "basic");
    do_reset();
    run4(3, 6, "step");

    // Backpressure: OutReady low for 6 cycles; unaccepted junk must not
    // reach the step-check history.
    do_reset();
    or4 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      iv4 = 1'b1;
      g4  = (c < 2) ? bp_code[c] : 4'b1100;
      #1;
      check("bp_in_ready", 32'(ir4), (c < 2) ? 32'd1 : 32'd0);
      if (c >= 2) begin
        check("bp_hold_valid", 32'(ov4), 32'd1);
        check("bp_hold_bin", 32'(b4), 32'(bp_bin[0]));
        check("bp_hold_err", 32'(se4), 32'd0);
      end
      @(negedge Clk);
    end
    or4 = 1'b1;
    got = 0;
    nxt_i = 2;
    for (int c = 0; c < 20 && !(got == 4 && nxt_i == 4); c++) begin
      if (nxt_i < 4) begin
        iv4 = 1'b1;
        g4  = bp_code[nxt_i];
      end else begin
        iv4 = 1'b0;
      end
      #1;
      if (ov4 && got < 8) begin
        got_b[got] = b4;
        got_e[got] = se4;
        got++;
      end
      if (iv4 && ir4) nxt_i++;
      @(negedge Clk);
    end
    iv4 = 1'b0;
    check("bp_count", 32'(got), 32'd4);
    for (int i = 0; i < 4 && i < got; i++) begin
      check("bp_order_bin", 32'(got_b[i]), 32'(bp_bin[i]));
      check("bp_order_err", 32'(got_e[i]), 32'd0);
    end
    #1 check("bp_no_dup", 32'(ov4), 32'd0);

    // Reset with two codes in flight.
    do_reset();
    or4 = 1'b1;
    iv4 = 1'b1; g4 = 4'b0000; @(negedge Clk);
    g4 = 4'b1010; @(negedge Clk);
    g4 = 4'b0000; @(negedge Clk);
    iv4 = 1'b0;
    #1;
    check("mid_pre_valid", 32'(ov4), 32'd1);
    check("mid_pre_bin", 32'(b4), 32'hC);
    check("mid_pre_err", 32'(se4), 32'd1);
    nReset = 1'b0;
    #1;
    check("mid_rst_valid", 32'(ov4), 32'd0);
    check("mid_rst_bin", 32'(b4), 32'd0);
    check("mid_rst_err", 32'(se4), 32'd0);
    repeat (2) @(negedge Clk);
    nReset = 1'b1;
    #1;
    check("mid_post_ready", 32'(ir4), 32'd1);
    iv4 = 1'b1; g4 = 4'b1111;
    @(negedge Clk);
    iv4 = 1'b0;
    #1 check("mid_post_early", 32'(ov4), 32'd0);
    @(negedge Clk);
    #1;
    check("mid_post_valid", 32'(ov4), 32'd1);
    check("mid_post_bin", 32'(b4), 32'hA);
    check("mid_post_err", 32'(se4), 32'd0);

    // Full-range sweep on the 8-bit instance, including wrap to 0.
    do_reset();
    or8 = 1'b1;
    for (int c = 0; c < 257 + 2; c++) begin
      if (c < 257) begin
        iv8 = 1'b1;
        g8  = gray8(8'(c % 256));
      end else begin
        iv8 = 1'b0;
      end
      #1;
      if (c < 257) check("sweep_in_ready", 32'(ir8), 32'd1);
      @(negedge Clk);
      k = c - 2;
      if (k < 0) begin
        check("sweep_early_valid", 32'(ov8), 32'd0);
      end else begin
        check("sweep_valid", 32'(ov8), 32'd1);
        check("sweep_bin", 32'(b8), 32'(k % 256));
        check("sweep_err", 32'(se8), 32'd0);
      end
    end
    iv8 = 1'b0;

    // Random handshake against the reference model.
    do_reset();
    m_last = '0;
    m_has = 1'b0;
    occ = 0;
    prev_stall = 1'b0;
    prev_b = '0;
    prev_e = 1'b0;
    exp_q.delete();
    for (int cyc = 0; cyc < 10000; cyc++) begin
      iv8 = ($urandom_range(0, 3) != 0);
      or8 = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 6)      g8 = gray8(8'(ref_bin(32'(m_last)) + 1));
      else if (r < 8) g8 = m_last;
      else            g8 = 8'($urandom_range(0, 255));
      #1;
      check("rnd_in_ready", 32'(ir8), (occ < 3 || or8) ? 32'd1 : 32'd0);
      if (occ == 0) check("rnd_idle_valid", 32'(ov8), 32'd0);
      if (prev_stall) begin
        check("rnd_stall_valid", 32'(ov8), 32'd1);
        check("rnd_stall_bin", 32'(b8), 32'(prev_b));
        check("rnd_stall_err", 32'(se8), 32'(prev_e));
      end
      acc = iv8 && ir8;
      con = ov8 && or8;
      if (con) begin
        check("rnd_out_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("rnd_bin", 32'(b8), 32'(e.bin));
          check("rnd_err", 32'(se8), 32'(e.err));
        end
      end
      if (acc) begin
        m_err = m_has && (hamming(32'(g8), 32'(m_last)) > 1);
        exp_q.push_back('{8'(ref_bin(32'(g8))), m_err});
        m_last = g8;
        m_has = 1'b1;
      end
      occ = occ + (acc ? 1 : 0) - (con ? 1 : 0);
      prev_stall = ov8 && !or8;
      prev_b = b8;
      prev_e = se8;
      @(negedge Clk);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      #1;
      if (ov8) begin
        e = exp_q.pop_front();
        check("drain_bin", 32'(b8), 32'(e.bin));
        check("drain_err", 32'(se8), 32'(e.err));
      end
      @(negedge Clk);
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    #1 check("drain_idle", 32'(ov8), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
